// File: rtl/reg_word_serializer.sv
// Parallel-to-serial unloader: one-word hold buffer feeding a shift engine,
// with per-bit valid and frame start/end strobes. Back-to-back words stream without gaps.
module reg_word_serializer #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             C,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] D,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [WIDTH-1:0]  sr;
    logic [WIDTH-1:0]  hb;
    logic              hb_full;
    logic [CW-1:0]     cnt;
    logic              last;
    logic              drain;
    logic              shift_en;
    logic              load_fire;
    logic [WIDTH-1:0]  sr_shifted;

    always_comb begin
        last       = (cnt == CW'(WIDTH - 1));
        shift_en   = (state == SHIFT) && C;
        // Refill the shifter from the hold buffer either from IDLE or on the last bit of a frame.
        drain      = C && hb_full && ((state == IDLE) || ((state == SHIFT) && last));
        load_fire  = load_valid && !hb_full;
        sr_shifted = LSB_FIRST ? {1'b0, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (C && hb_full) state_nx = SHIFT;
            SHIFT:   if (C && last && !hb_full) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            sr      <= '0;
            hb      <= '0;
            hb_full <= 1'b0;
            cnt     <= '0;
        end else begin
            if (drain) begin
                sr      <= hb;
                hb_full <= 1'b0;
                cnt     <= '0;
            end else if (shift_en) begin
                sr  <= sr_shifted;
                cnt <= last ? '0 : cnt + CW'(1);
            end
            // load_fire requires an empty buffer, so it never coincides with drain.
            if (load_fire) begin
                hb      <= D;
                hb_full <= 1'b1;
            end
        end
    end

    always_comb begin
        load_ready  = !hb_full;
        sdo         = LSB_FIRST ? sr[0] : sr[WIDTH-1];
        sdo_valid   = shift_en;
        frame_start = shift_en && (cnt == '0);
        frame_end   = shift_en && last;
        busy        = (state == SHIFT) || hb_full;
    end

endmodule

// File: doc/reg_word_serializer.md
# reg_word_serializer

Parallel-to-serial unloader for 32-bit register words: accepts a word over a valid/ready load handshake, buffers one word, and shifts it out one bit per enabled clock with frame strobes. It is the transmit-side partner to the team's gated 32-bit parallel-load register. A word captured in a register is drained here onto a single serial line. Back-to-back words stream gaplessly.

## Interface
- WIDTH, 32: word width in bits (≥2); counter width is clog2(WIDTH).
- LSB_FIRST, 0: 0 = shift MSB first, 1 = LSB first.

- clk  in  1  system clock, all state on rising edge.
- clear  in  1  reset, synchronous, active-high.
- C  in  1  shift enable; 0 freezes the shift engine (hold buffer still accepts).
- load_valid  in  1  D holds a word to send.
- load_ready  out  1  hold buffer empty; transfer occurs when load_valid && load_ready at an edge.
- D  in  WIDTH  word to serialize.
- sdo  out  1  serial data bit.
- sdo_valid  out  1  sdo carries a live bit this cycle.
- frame_start  out  1  sdo_valid && current bit is bit 0 of the frame.
- frame_end  out  1  sdo_valid && current bit is the last bit of the frame.
- busy  out  1  engine shifting or word held.

## Operation
- State: FSM {IDLE, SHIFT}, shift register sr[WIDTH], bit counter cnt, hold buffer hb[WIDTH] and hb_full flag.
- Reset (clear=1 at edge, overrides all): state=IDLE, sr=0, cnt=0, hb=0, hb_full=0. Outputs after reset: load_ready=1, sdo=0, sdo_valid=0, frame_start=0, frame_end=0, busy=0.
- load_ready = !hb_full (registered-state derived, no combinational path from load_valid).
- Accept: load_valid && load_ready → hb<=D, hb_full<=1. Independent of C.
- IDLE, C=1, hb_full=1 → sr<=hb, hb_full<=0, cnt<=0, state<=SHIFT.
- IDLE with C=0 or hb_full=0 → hold.
- SHIFT, C=1: sdo_valid=1; at the edge sr shifts one place toward the output end (zero-fill), cnt<=cnt+1.
  - On cnt==WIDTH-1 with hb_full=1: sr<=hb, hb_full<=0, cnt<=0, stay in SHIFT (gapless next frame).
  - On cnt==WIDTH-1 with hb_full=0: state<=IDLE, cnt<=0.
- SHIFT, C=0: sr, cnt, state frozen; sdo_valid=0; sdo still shows the pending bit.
- sdo = sr[WIDTH-1] when LSB_FIRST=0, sr[0] when LSB_FIRST=1. Combinational from sr.
- busy = (state==SHIFT) || hb_full.
- Accepting at the same edge hb is drained to sr is impossible: load_ready=0 while hb_full. A new word is accepted the edge after the drain.
- A clear mid-frame aborts: no frame_end is produced, and the held word is discarded.

## Timing
- Edge k denotes the rising edge; cycle k denotes the period after it.
- Word accepted at edge 0 in IDLE with C held 1: transfer to sr at edge 1; bits valid in cycles 1..WIDTH; frame_start in cycle 1; frame_end in cycle WIDTH; IDLE after edge WIDTH+1 if no further word.
- Per-frame throughput is WIDTH enabled cycles. Back-to-back frames have zero idle cycles if the next word is accepted at least one edge before the current frame's last shift edge.
- C low for n cycles mid-frame stretches the frame by exactly n cycles. No bit is lost or duplicated.
- Output latency from accept to first valid bit is 1 cycle, with C=1.

## Test plan
- Reset: assert clear 2 cycles mid-frame, then check load_ready=1, busy=0, sdo_valid=0, sdo=0 next cycle; no frame_end from the aborted frame.
- Single word, MSB first: D=32'hA5C3_0F81 accepted edge 0, C=1. Sampled sdo cycles 1..32 rebuild 32'hA5C3_0F81; frame_start only in cycle 1; frame_end only in cycle 32; busy=0 from cycle 33.
- Back-to-back: send 32'hFFFF_0000 then 32'h1234_5678, second accepted while the first shifts. Exactly 64 consecutive sdo_valid cycles with frame_end in cycles 32 and 64, and load_ready=0 while hb_full.
- Stall: same word as the single-word case, C=0 in cycles 10–14. Word reconstructs correctly; frame_end in cycle 37; sdo_valid=0 during the stall; a load_valid in the stall is still accepted if hb is empty.
- LSB_FIRST=1, WIDTH=8: D=8'h81 yields sdo sequence 1,0,0,0,0,0,0,1; D=8'h01 yields 1 then seven 0s.
- Handshake: load_valid held high continuously with an incrementing D. Every accepted word appears once, in order, none dropped or repeated, across 4 frames.
